int_to_float_seq: RTL and testbench



---
 rtl/int_to_float_seq.sv | 91 +++++++++
 tb/tb_int_to_float_seq.sv | 122 ++++++++++++
 2 files changed

// File: rtl/int_to_float_seq.sv
// int_to_float_seq: iterative signed-integer to packed-float converter, truncating, valid/ready on both sides
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_data: integer input handshake;
//        out_valid/out_ready/out_data: packed {sign, exponent, mantissa} result handshake; busy: not idle.
module int_to_float_seq #(
  parameter int BITS      = 32,
  parameter int EXP_WIDTH = 8,
  parameter int INT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INT_WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BITS-1:0]      out_data,
  output logic                 busy
);
  localparam int MAN  = BITS - EXP_WIDTH - 1;
  localparam int BIAS = 2 ** (EXP_WIDTH - 1) - 1;
  localparam int W    = INT_WIDTH - 1 + MAN;
  if (INT_WIDTH - 1 + BIAS > 2 ** EXP_WIDTH - 2) begin : g_bad_params
    $error("int_to_float_seq: INT_WIDTH-1+bias exceeds the largest finite exponent");
  end
  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
  state_t               state, state_n;
  logic [INT_WIDTH-1:0] mag, mag_n, abs_in, shifted;
  logic [EXP_WIDTH-1:0] e, e_n;
  logic                 sign, sign_n;
  logic [BITS-1:0]      data_n;
  // Fraction bits sit below the leading one; zero-pad on the right when the integer is narrower than MAN.
  function automatic logic [BITS-1:0] pack(input logic s, input logic [INT_WIDTH-2:0] frac,
                                           input logic [EXP_WIDTH-1:0] x);
    logic [W-1:0] ext;
    ext = {frac, {MAN{1'b0}}};
    return {s, x + EXP_WIDTH'(BIAS), ext[W-1 -: MAN]};
  endfunction
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  // The leading-one test is applied to the value about to be stored, so a magnitude with
  // L leading zeros reaches DONE exactly L cycles after acceptance.
  always_comb begin
    abs_in  = in_data[INT_WIDTH-1] ? -in_data : in_data;
    shifted = mag << 1;
    state_n = state;
    mag_n   = mag;
    e_n     = e;
    sign_n  = sign;
    data_n  = out_data;
    case (state)
      IDLE: if (in_valid) begin
        sign_n = in_data[INT_WIDTH-1];
        mag_n  = abs_in;
        e_n    = EXP_WIDTH'(INT_WIDTH - 1);
        if (abs_in == '0) begin
          data_n  = '0;
          state_n = DONE;
        end else if (abs_in[INT_WIDTH-1]) begin
          data_n  = pack(in_data[INT_WIDTH-1], abs_in[INT_WIDTH-2:0], e_n);
          state_n = DONE;
        end else state_n = NORM;
      end
      NORM: begin
        mag_n = shifted;
        e_n   = e - 1'b1;
        if (shifted[INT_WIDTH-1]) begin
          data_n  = pack(sign, shifted[INT_WIDTH-2:0], e_n);
          state_n = DONE;
        end
      end
      DONE:    state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mag      <= '0;
      e        <= '0;
      sign     <= 1'b0;
      out_data <= '0;
    end else begin
      state    <= state_n;
      mag      <= mag_n;
      e        <= e_n;
      sign     <= sign_n;
      out_data <= data_n;
    end
  end
endmodule

// File: tb/tb_int_to_float_seq.sv
// tb_int_to_float_seq: randomized and directed checks of int_to_float_seq against an arithmetic reference
module tb_int_to_float_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b1;
  logic        in_ready;
  logic [31:0] in_data = 32'd5;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        busy;
  int checks = 0;
  int errors = 0;
  int_to_float_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  // Reference: locate the leading one arithmetically and scale the remainder into 23 bits.
  function automatic logic [31:0] ref_float(input logic [31:0] v, output int lat);
    longint m, frac, man;
    int p;
    logic s;
    lat = 0;
    if (v == 0) return 32'h0;
    s = v[31];
    m = s ? (longint'(1) << 32) - longint'(v) : longint'(v);
    p = 0;
    while ((longint'(1) << (p + 1)) <= m) p++;
    frac = m - (longint'(1) << p);
    man  = p >= 23 ? frac >> (p - 23) : frac << (23 - p);
    lat  = 31 - p;
    return {s, 8'(p + 127), 23'(man)};
  endfunction
  task automatic convert(input logic [31:0] v, input int stall);
    logic [31:0] exp_f;
    int exp_lat, cyc;
    exp_f = ref_float(v, exp_lat);
    @(negedge clk);
    chk("ready_before", in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = v;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("latency_%0h", v), cyc, exp_lat);
    chk($sformatf("data_%0h", v), out_data, exp_f);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("hold_data", out_data, exp_f);
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_ready", in_ready, 1'b0);
      chk("hold_busy", busy, 1'b1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_cleared", out_valid, 1'b0);
    chk("idle_ready", in_ready, 1'b1);
  endtask
  initial begin
    logic [31:0] v;
    repeat (3) @(negedge clk);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    chk("rst_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("stray_ready_valid", out_valid, 1'b0);
    out_ready = 1'b0;
    convert(32'd1, 0);
    convert(32'hFFFFFFFF, 0);
    convert(32'd5, 0);
    convert(32'd0, 0);
    convert(32'h80000000, 0);
    convert(32'h7FFFFFFF, 0);
    convert(32'd3, 10);
    convert(32'd2, 0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'd1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("norm_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ready", in_ready, 1'b1);
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_data", out_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (35) begin
      @(negedge clk);
      chk("no_stale_result", out_valid, 1'b0);
    end
    convert(32'd7, 0);
    for (int i = 0; i < 40; i++) begin
      v = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) v = -v;
      convert(v, $urandom_range(0, 3));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
